// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_queue
//  Description : Fetch stage. Holds the fetch PC, addresses a zero-latency
//                instruction ROM and queues {pc, word} pairs in a small FIFO
//                that feeds decode over a valid/ready handshake. A redirect
//                flushes the queue and reloads the PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   pc_mem_q   [DEPTH];
    logic [31:0]   data_mem_q [DEPTH];

    logic          push;
    logic          pop;

    // The two low bits of a redirect target carry no information.
    logic          redirect_unused_bits;
    assign redirect_unused_bits = ^redirect_pc[1:0];

    // Handshake qualifiers; outputs depend only on registered state.
    assign inst_valid = (count_q != '0);
    assign pop        = inst_valid & inst_ready;
    assign push       = fetch_en & ~redirect_valid & ((count_q < DEPTH_CNT) | pop);

    assign imem_addr  = fetch_pc_q;
    assign inst_data  = inst_valid ? data_mem_q[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : 32'h0;

    // Next-state for PC, pointers and occupancy; redirect flushes everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d   = wr_ptr_q + 1'b1;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            data_mem_q[wr_ptr_q] <= imem_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_queue
//  Description : Bench for instr_fetch_queue with a queue-based reference
//                model, directed scenarios and randomized traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;

    int total = 0;
    int bad   = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc)
    );

    always #5 clk = ~clk;

    // Instruction ROM contents: distinct word per address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return ((a >> 2) * 32'h0001_0003) ^ 32'h5A5A_0000;
    endfunction

    always_comb imem_data = rom(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, word} pairs plus the fetch PC.
    logic [63:0] mq[$];
    logic [31:0] mpc;
    bit          model_live = 0;

    always @(posedge clk) begin
        bit m_pop, m_push;
        if (!reset) begin
            mq.delete();
            mpc        = RESET_PC;
            model_live = 1;
        end else if (redirect_valid) begin
            mq.delete();
            mpc = {redirect_pc[31:2], 2'b00};
        end else begin
            m_pop  = (mq.size() > 0) && inst_ready;
            m_push = fetch_en && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back({mpc, rom(mpc)});
                mpc = mpc + 32'd4;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (model_live) begin
            chk("model_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
            chk("model_pc",    inst_pc,   (mq.size() != 0) ? mq[0][63:32] : 32'h0);
            chk("model_data",  inst_data, (mq.size() != 0) ? mq[0][31:0]  : 32'h0);
            chk("model_addr",  imem_addr, mpc);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; inst_ready = 1'b0;
        #2;
        do_reset();

        // Reset state
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_data",  inst_data, 32'h0);
        chk("rst_pc",    inst_pc,   32'h0);
        chk("rst_addr",  imem_addr, RESET_PC);

        // Streaming: one instruction per cycle, no bubbles
        fetch_en = 1'b1; inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk("stream_valid", {31'b0, inst_valid}, 32'd1);
            chk("stream_pc",    inst_pc,   32'(4 * k));
            chk("stream_data",  inst_data, rom(32'(4 * k)));
        end

        // Backpressure until full
        do_reset();
        fetch_en = 1'b1; inst_ready = 1'b0;
        cyc(6);
        chk("full_addr", imem_addr, 32'h10);
        chk("full_pc",   inst_pc,   32'h0);

        // Pop and push at full in the same edge
        inst_ready = 1'b1;
        cyc();
        chk("popfull_addr", imem_addr, 32'h14);
        chk("popfull_pc",   inst_pc,   32'h4);

        // Drain one without fetching, leaving three queued
        fetch_en = 1'b0;
        cyc();
        chk("three_pc", inst_pc, 32'h8);

        // Redirect with a pop request in the same cycle
        fetch_en = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h2A;
        cyc();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'b0, inst_valid}, 32'd0);
        chk("redir_addr",  imem_addr, 32'h28);
        cyc();
        chk("redir_pc",   inst_pc,   32'h28);
        chk("redir_data", inst_data, rom(32'h28));

        // Halt with two entries queued
        inst_ready = 1'b0;
        cyc();
        fetch_en = 1'b0; inst_ready = 1'b1;
        cyc(3);
        chk("halt_valid", {31'b0, inst_valid}, 32'd0);
        chk("halt_addr",  imem_addr, 32'h30);
        fetch_en = 1'b1;
        cyc();
        chk("resume_pc", inst_pc, 32'h30);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFB;
        cyc();
        redirect_valid = 1'b0;
        cyc(3);
        chk("wrap_pc",   inst_pc,   32'h0);
        chk("wrap_addr", imem_addr, 32'h4);

        // Reset while full with a redirect pending
        inst_ready = 1'b0;
        cyc(5);
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h100;
        cyc();
        chk("mrst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mrst_data",  inst_data, 32'h0);
        chk("mrst_pc",    inst_pc,   32'h0);
        chk("mrst_addr",  imem_addr, RESET_PC);
        reset = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b1;
        cyc();
        chk("restart_pc", inst_pc, RESET_PC);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 99) != 0);
            fetch_en       = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 9) < 6);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom();
            cyc();
        end

        reset = 1'b1; redirect_valid = 1'b0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage sitting directly upstream of the combinational instruction ROM (word-indexed by addr[31:2], zero read latency) and downstream into decode.
- Holds the fetch PC, drives the ROM address, captures each returned word with its PC into a small FIFO, and presents instructions to decode over a valid/ready handshake.
- Supports a same-cycle redirect (branch/jal/jalr target) that flushes queued instructions, and a fetch enable for halting.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset; must be word-aligned.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- imem_addr  output  32  ROM address; equals fetch_pc.
- imem_data  input  32  ROM read data for imem_addr, valid in the same cycle.
- fetch_en  input  1  1 = fetch allowed; 0 = no push and fetch_pc holds. Queue still drains.
- redirect_valid  input  1  flush queue and load a new fetch PC.
- redirect_pc  input  32  redirect target; bits [1:0] ignored.
- inst_valid  output  1  queue head valid.
- inst_ready  input  1  decode accepts the head this cycle.
- inst_data  output  32  head instruction word; 0 when inst_valid=0.
- inst_pc  output  32  PC of the head instruction; 0 when inst_valid=0.

Behaviour:
- Reset (reset=0 at a rising edge): fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0. Resulting outputs are inst_valid=0, inst_data=0, inst_pc=0, imem_addr=RESET_PC. Reset overrides redirect, push and pop, including mid-stream; queued contents are discarded.
- pop = inst_valid & inst_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).
  - push writes {fetch_pc, imem_data} at wr_ptr and advances fetch_pc by 4.
  - fetch_pc is a 32-bit modulo add; 0xFFFF_FFFC wraps to 0.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
  - count_next = count + push - pop.
- Latency: a word fetched at edge N is visible on inst_* after edge N. inst_* are driven from the head entry and are combinational from registered state only.
- No ready-to-valid combinational path: inst_valid must not depend on inst_ready.
- Full (count=DEPTH): push occurs only if pop occurs the same edge. Otherwise imem_addr and fetch_pc hold.
- Empty (count=0): inst_valid=0, and inst_ready is ignored.
- Redirect (redirect_valid=1 at an edge) has priority over push and pop:
  - count=0, both pointers reset to 0.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - No pop is counted, even if inst_valid & inst_ready.
  - Next cycle: imem_addr = new PC, inst_valid=0. The first redirected instruction appears after the following edge, giving a 2-edge redirect-to-valid latency.
- Redirect with fetch_en=0: fetch_pc still loads the target and the queue still flushes.
- fetch_en=0: no push and fetch_pc holds. Pops continue until empty.
- No combinational path from redirect_valid to imem_addr; imem_addr is always the fetch_pc register.

Test Plan:
- Stream: RESET_PC=0, program ROM words 0..5, fetch_en=1, inst_ready=1.
  - Expect after the first post-reset edge: inst_valid=1, inst_pc=0x0, inst_data=word0.
  - Then one instruction per cycle with inst_pc 0x4, 0x8, 0xC…; no bubbles.
- Backpressure/full: inst_ready=0 for 6 cycles.
  - Expect count to saturate at 4, imem_addr frozen at 0x10, inst_pc held at 0x0.
  - Raise inst_ready: PCs 0x0, 0x4, 0x8, 0xC, 0x10 emerge in order with no loss or duplication.
- Pop+push at full: count=4, inst_ready=1 for one cycle.
  - Expect count stays 4 and imem_addr advances 0x10→0x14.
- Redirect: with 3 entries queued, assert redirect_valid, redirect_pc=0x2A, and inst_ready=1 in the same cycle.
  - Next cycle: inst_valid=0, imem_addr=0x28.
  - One edge later: inst_pc=0x28, inst_data=word10.
- Halt: fetch_en=0 with 2 entries queued and inst_ready=1.
  - Both drain, then inst_valid=0 while imem_addr holds its value.
  - Re-enable fetch: fetch resumes from the held PC.
- Reset mid-operation: reset=0 for one edge while full and redirect_valid=1.
  - Expect inst_valid=0, inst_data=0, inst_pc=0, imem_addr=RESET_PC.
  - Stream restarts from RESET_PC.
